// File: rtl/fp16_pkg.sv
// Shared widths, packed FP16 result type and stage-1 classification for the FP16 add normalizer.
package fp16_pkg;

  localparam int unsigned EXP_W    = 5;
  localparam int unsigned MAN_W    = 10;
  localparam int unsigned EXP_MAX  = 31;
  localparam int unsigned HIDDEN_W = MAN_W + 1;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] frac;
  } fp16_t;

  typedef enum logic [1:0] {
    KIND_NORM,
    KIND_PASS,
    KIND_FLUSH,
    KIND_CANCEL
  } s1_kind_e;

endpackage

// File: rtl/fp16_add_normalize_if.sv
// Valid/ready bus between the exponent-alignment stage, the normalizer and its consumer.
interface fp16_add_normalize_if;
  import fp16_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic [EXP_W+MAN_W-1:0]   bigger;
  logic [HIDDEN_W-1:0]      aligned_small;
  logic                     eff_sub;
  logic                     sign_big;
  logic                     out_valid;
  logic                     out_ready;
  logic [EXP_W+MAN_W:0]     result;

  modport slave (
    input  in_valid, bigger, aligned_small, eff_sub, sign_big, out_ready,
    output in_ready, out_valid, result
  );

  modport master (
    output in_valid, bigger, aligned_small, eff_sub, sign_big, out_ready,
    input  in_ready, out_valid, result
  );

endinterface

// File: rtl/fp16_lzc11.sv
// Combinational leading-zero count of an 11-bit mantissa; all-zero input returns 11.
module fp16_lzc11 (
  input  logic [10:0] i_vec,
  output logic [3:0]  o_lz
);

  // Scanning upward lets the highest set bit win without a found flag.
  always_comb begin
    o_lz = 4'd11;
    for (int unsigned i = 0; i < 11; i++) begin
      if (i_vec[i]) o_lz = 4'(10 - i);
    end
  end

endmodule

// File: rtl/fp16_add_normalize.sv
// FP16 add/sub, normalize and pack in a 2-stage valid/ready pipeline.
// Optional status flags (ovf/unf/zero) are built when FP16_ADD_STATUS_FLAGS_EN is defined.
module fp16_add_normalize #(
  parameter int unsigned EXP_W = fp16_pkg::EXP_W,
  parameter int unsigned MAN_W = fp16_pkg::MAN_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fp16_add_normalize_if.slave   s_if
`ifdef FP16_ADD_STATUS_FLAGS_EN
  ,
  output logic                  flag_ovf,
  output logic                  flag_unf,
  output logic                  flag_zero
`endif
);
  import fp16_pkg::fp16_t;
  import fp16_pkg::s1_kind_e;
  import fp16_pkg::KIND_NORM;
  import fp16_pkg::KIND_PASS;
  import fp16_pkg::KIND_FLUSH;
  import fp16_pkg::KIND_CANCEL;

  localparam int unsigned HID_W = MAN_W + 1;
  localparam int unsigned SUM_W = MAN_W + 2;
  localparam logic [EXP_W-1:0]        EXP_ALL1 = '1;
  localparam logic signed [EXP_W:0]   EXP_LIM  = $signed({1'b0, EXP_ALL1});
  localparam logic signed [EXP_W:0]   EXP_ZERO = '0;

  logic w_s1_adv, w_s2_adv;

  logic [EXP_W-1:0] w_in_exp;
  logic [MAN_W-1:0] w_in_frac;
  logic [HID_W-1:0] w_in_m;
  logic [SUM_W-1:0] w_sum;
  logic [HID_W-1:0] w_diff;
  s1_kind_e         w_kind;

  logic             r_s1_valid;
  s1_kind_e         r_s1_kind;
  logic             r_s1_sign;
  logic             r_s1_sub;
  logic [EXP_W-1:0] r_s1_exp;
  logic [MAN_W-1:0] r_s1_frac;
  logic [SUM_W-1:0] r_s1_arith;

  logic [3:0]              w_lz;
  logic [MAN_W-1:0]        w_mant;
  logic signed [EXP_W:0]   w_exp_adj;
  logic                    w_is_norm, w_ovf, w_unf;
  fp16_t                   w_pack;

  logic  r_s2_valid;
  fp16_t r_s2_result;

  assign w_s2_adv = !r_s2_valid || s_if.out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;

  assign s_if.in_ready  = w_s1_adv;
  assign s_if.out_valid = r_s2_valid;
  assign s_if.result    = r_s2_result;

  // Stage 1: effective add/subtract and special-operand classification
  assign w_in_exp  = s_if.bigger[EXP_W+MAN_W-1 -: EXP_W];
  assign w_in_frac = s_if.bigger[MAN_W-1:0];
  assign w_in_m    = {1'b1, w_in_frac};
  assign w_sum     = {1'b0, w_in_m} + {1'b0, s_if.aligned_small};
  assign w_diff    = w_in_m - s_if.aligned_small;

  always_comb begin
    if (w_in_exp == EXP_ALL1)                    w_kind = KIND_PASS;
    else if (w_in_exp == '0)                     w_kind = KIND_FLUSH;
    else if (s_if.eff_sub && (w_diff == '0))     w_kind = KIND_CANCEL;
    else                                         w_kind = KIND_NORM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_kind  <= KIND_NORM;
      r_s1_sign  <= 1'b0;
      r_s1_sub   <= 1'b0;
      r_s1_exp   <= '0;
      r_s1_frac  <= '0;
      r_s1_arith <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= s_if.in_valid;
      if (s_if.in_valid) begin
        r_s1_kind  <= w_kind;
        r_s1_sign  <= s_if.sign_big;
        r_s1_sub   <= s_if.eff_sub;
        r_s1_exp   <= w_in_exp;
        r_s1_frac  <= w_in_frac;
        r_s1_arith <= s_if.eff_sub ? {1'b0, w_diff} : w_sum;
      end
    end
  end

  // Stage 2: normalize, adjust exponent, resolve overflow/underflow and pack
  fp16_lzc11 u_lzc (
    .i_vec (r_s1_arith[HID_W-1:0]),
    .o_lz  (w_lz)
  );

  always_comb begin
    if (r_s1_sub) begin
      w_mant    = MAN_W'(r_s1_arith[HID_W-1:0] << w_lz);
      w_exp_adj = $signed({1'b0, r_s1_exp}) - $signed({{(EXP_W-3){1'b0}}, w_lz});
    end else if (r_s1_arith[SUM_W-1]) begin
      w_mant    = r_s1_arith[MAN_W:1];
      w_exp_adj = $signed({1'b0, r_s1_exp} + {{EXP_W{1'b0}}, 1'b1});
    end else begin
      w_mant    = r_s1_arith[MAN_W-1:0];
      w_exp_adj = $signed({1'b0, r_s1_exp});
    end
  end

  assign w_is_norm = (r_s1_kind == KIND_NORM);
  assign w_ovf     = w_is_norm && (w_exp_adj >= EXP_LIM);
  assign w_unf     = w_is_norm && !w_ovf && (w_exp_adj <= EXP_ZERO);

  always_comb begin
    w_pack = '0;
    case (r_s1_kind)
      KIND_PASS: begin
        w_pack.sign = r_s1_sign;
        w_pack.exp  = '1;
        w_pack.frac = r_s1_frac;
      end
      KIND_FLUSH:  w_pack.sign = r_s1_sign;
      KIND_CANCEL: w_pack = '0;
      KIND_NORM: begin
        w_pack.sign = r_s1_sign;
        if (w_ovf) begin
          w_pack.exp = '1;
        end else if (!w_unf) begin
          w_pack.exp  = w_exp_adj[EXP_W-1:0];
          w_pack.frac = w_mant;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) r_s2_result <= w_pack;
    end
  end

`ifdef FP16_ADD_STATUS_FLAGS_EN
  logic r_flag_ovf, r_flag_unf, r_flag_zero;

  // Flags are loaded alongside valid, so they read 0 whenever out_valid is 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag_ovf  <= 1'b0;
      r_flag_unf  <= 1'b0;
      r_flag_zero <= 1'b0;
    end else if (w_s2_adv) begin
      r_flag_ovf  <= r_s1_valid && w_ovf;
      r_flag_unf  <= r_s1_valid && w_unf;
      r_flag_zero <= r_s1_valid && (r_s1_kind == KIND_CANCEL);
    end
  end

  assign flag_ovf  = r_flag_ovf;
  assign flag_unf  = r_flag_unf;
  assign flag_zero = r_flag_zero;
`endif

endmodule

// File: doc/fp16_add_normalize.md
Name: fp16_add_normalize

Overview:
- Downstream neighbour of the half-precision exponent-alignment stage in the FP16 adder path of the systolic PE.
- Takes the larger operand's exponent/fraction, the already-shifted smaller mantissa, and sign information.
- Performs the effective add/subtract, leading-zero normalization, exponent adjust and overflow/underflow handling.
- Emits a packed FP16 result through a 2-stage valid/ready pipeline.

Parameters:
- EXP_W, 5, exponent width.
- MAN_W, 10, stored fraction width; the hidden bit is implicit.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset: asynchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat.
- bigger  in  EXP_W+MAN_W  larger-magnitude operand as {exp, frac}.
- aligned_small  in  MAN_W+1  smaller mantissa with hidden 1, already right-shifted.
- eff_sub  in  1  1 = operand signs differ (subtract).
- sign_big  in  1  sign of the larger operand; this is the result sign.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  1+EXP_W+MAN_W  packed FP16 {sign, exp, frac}.

Behaviour:
- Reset (async assert, sync release): all stage valid bits = 0; out_valid = 0; result = 0. in_ready = 1 after reset.
- Pipeline: S1 = add/sub and special detect; S2 = LZC, shift, exponent adjust, pack.
  - Latency is 2 cycles from the accepted input to out_valid when out_ready = 1.
  - Throughput is 1 beat per cycle.
- Handshake:
  - A beat transfers when valid && ready.
  - S2 advances when !s2_valid || out_ready. S1 advances when !s1_valid || S2 advances. in_ready = that S1 condition.
  - result and out_valid hold stable while out_valid && !out_ready. No beat is dropped or duplicated.
- Arithmetic:
  - M = {1, bigger frac} (11 bits). E = bigger exp.
  - Add: sum = M + aligned_small (12 bits).
    - If sum[11] = 1: mant = sum[11:1], E+1.
    - Otherwise: mant = sum[10:0], E.
  - Sub: diff = M − aligned_small (11 bits, never negative).
    - lz = leading zeros of diff[10:0]; mant = diff << lz; exponent = E − lz, evaluated with 6-bit signed arithmetic.
  - Rounding: truncate toward zero. No guard or sticky bits exist upstream.
- Special cases, in priority order:
  - E == 31 (inf/NaN): pass through as {sign_big, bigger}.
  - E == 0: result = {sign_big, 0}. Subnormals are unsupported and flushed.
  - Sub with diff == 0: result = +0 (16'h0000).
  - Adjusted exponent ≥ 31: result = {sign_big, 5'h1F, 10'h0} (infinity).
  - Adjusted exponent ≤ 0: result = {sign_big, 0} (flush to zero).
  - Otherwise: {sign_big, exp[4:0], mant[9:0]}.
- Reset asserted mid-operation: in-flight beats are discarded and out_valid drops immediately.

Optional Feature:
- Macro: FP16_ADD_STATUS_FLAGS_EN.
- Defined: adds three 1-bit outputs, registered with result and valid only with out_valid (0 otherwise), reset 0:
  - flag_ovf: infinity created by overflow.
  - flag_unf: nonzero result flushed to zero.
  - flag_zero: exact cancellation.
- Undefined: these ports and their logic do not exist. Results are identical in both builds.

Decomposition:
- Package fp16_pkg holds:
  - EXP_W, MAN_W, EXP_MAX (31), HIDDEN_W (MAN_W+1).
  - A packed fp16 struct {sign, exp, frac}.
- One sub-module: fp16_lzc11, a combinational leading-zero count of an 11-bit vector returning 4 bits; all-zero input returns 11.

Test Plan:
1. 1.0 + 1.0: bigger = 15'h3C00, aligned_small = 11'h400, eff_sub = 0, sign_big = 0 -> result 16'h4000 two cycles after acceptance.
2. 1.5 − 1.0: bigger = 15'h3E00, aligned_small = 11'h400, eff_sub = 1 -> result 16'h3800 (lz = 1).
3. Exact cancel: bigger = 15'h3C00, aligned_small = 11'h400, eff_sub = 1, sign_big = 1 -> result 16'h0000; flag_zero = 1 when the macro is defined.
4. Overflow: bigger = 15'h7BFF, aligned_small = 11'h7FF, eff_sub = 0, sign_big = 1 -> result 16'hFC00; flag_ovf = 1.
5. Underflow: bigger = 15'h0600, aligned_small = 11'h400, eff_sub = 1 -> result 16'h0000; flag_unf = 1.
6. Backpressure and reset:
   - Stream 4 beats with out_ready low for 3 cycles. Required: in_ready drops after 2 beats are buffered, result is held stable, and all 4 results appear in order.
   - Pulse rst_n low mid-stream. Required: out_valid = 0 immediately and no stale beat appears afterwards.
